// File: rtl/id_ex_stage_pkg.sv
// Shared CPU definitions for the ID/EX stage: ALU operation codes,
// bubble constants and default datapath widths.
package id_ex_stage_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int CONF_W_DEF     = 5;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int SHAMT_W        = 5;

  typedef enum logic [4:0] {
    ALU_AND = 5'd0,
    ALU_OR  = 5'd1,
    ALU_ADD = 5'd2,
    ALU_SUB = 5'd3,
    ALU_XOR = 5'd4,
    ALU_NOR = 5'd5,
    ALU_SLT = 5'd6,
    ALU_SLL = 5'd7,
    ALU_SRL = 5'd8,
    ALU_SRA = 5'd9
  } alu_conf_e;

  // A bubble is an all-zero register image: AND with no side effects, rd=$0.
  localparam logic [4:0] BUBBLE_CONF = ALU_AND;
  localparam logic [4:0] BUBBLE_RD   = 5'd0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: ID-side decoded fields, forwarding sources from EX/MEM and
// MEM/WB, and the EX-side outputs to the ALU and later stages.
// master = the surrounding pipeline (drives i_*), slave = the stage itself.
interface id_ex_stage_if #(
  parameter int DATA_W     = 32,
  parameter int CONF_W     = 5,
  parameter int REG_ADDR_W = 5
);
  logic                  i_stall;
  logic                  i_flush;
  logic                  i_id_valid;
  logic [CONF_W-1:0]     i_id_alu_conf;
  logic                  i_id_sign;
  logic [DATA_W-1:0]     i_id_rs_data;
  logic [DATA_W-1:0]     i_id_rt_data;
  logic [DATA_W-1:0]     i_id_imm;
  logic [4:0]            i_id_shamt;
  logic                  i_id_src_a_shamt;
  logic                  i_id_src_b_imm;
  logic [REG_ADDR_W-1:0] i_id_rs;
  logic [REG_ADDR_W-1:0] i_id_rt;
  logic [REG_ADDR_W-1:0] i_id_rd;
  logic                  i_id_reg_write;
  logic                  i_id_mem_read;
  logic                  i_id_mem_write;
  logic                  i_id_mem_to_reg;
  logic                  i_exmem_reg_write;
  logic [REG_ADDR_W-1:0] i_exmem_rd;
  logic [DATA_W-1:0]     i_exmem_result;
  logic                  i_memwb_reg_write;
  logic [REG_ADDR_W-1:0] i_memwb_rd;
  logic [DATA_W-1:0]     i_memwb_data;
  logic                  o_valid;
  logic [CONF_W-1:0]     o_alu_conf;
  logic                  o_alu_sign;
  logic [DATA_W-1:0]     o_alu_data_1;
  logic [DATA_W-1:0]     o_alu_data_2;
  logic [DATA_W-1:0]     o_store_data;
  logic [REG_ADDR_W-1:0] o_rd;
  logic                  o_reg_write;
  logic                  o_mem_read;
  logic                  o_mem_write;
  logic                  o_mem_to_reg;

  modport master (
    output i_stall, i_flush, i_id_valid, i_id_alu_conf, i_id_sign, i_id_rs_data,
           i_id_rt_data, i_id_imm, i_id_shamt, i_id_src_a_shamt, i_id_src_b_imm,
           i_id_rs, i_id_rt, i_id_rd, i_id_reg_write, i_id_mem_read, i_id_mem_write,
           i_id_mem_to_reg, i_exmem_reg_write, i_exmem_rd, i_exmem_result,
           i_memwb_reg_write, i_memwb_rd, i_memwb_data,
    input  o_valid, o_alu_conf, o_alu_sign, o_alu_data_1, o_alu_data_2, o_store_data,
           o_rd, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg
  );

  modport slave (
    input  i_stall, i_flush, i_id_valid, i_id_alu_conf, i_id_sign, i_id_rs_data,
           i_id_rt_data, i_id_imm, i_id_shamt, i_id_src_a_shamt, i_id_src_b_imm,
           i_id_rs, i_id_rt, i_id_rd, i_id_reg_write, i_id_mem_read, i_id_mem_write,
           i_id_mem_to_reg, i_exmem_reg_write, i_exmem_rd, i_exmem_result,
           i_memwb_reg_write, i_memwb_rd, i_memwb_data,
    output o_valid, o_alu_conf, o_alu_sign, o_alu_data_1, o_alu_data_2, o_store_data,
           o_rd, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg
  );
endinterface

// File: rtl/id_ex_stage_ex_forward_mux.sv
// EX-stage operand forwarding: 3-way priority select EX/MEM > MEM/WB > register.
// $0 is never forwarded. Forwarding exists only when EX_FORWARD_EN is defined;
// otherwise the registered operand passes straight through.
module ex_forward_mux #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0]     reg_data,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [DATA_W-1:0]     exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [DATA_W-1:0]     memwb_data,
  output logic [DATA_W-1:0]     fwd_data
);
`ifdef EX_FORWARD_EN
  logic src_nz;
  assign src_nz = |src_addr;

  // Younger producer (EX/MEM) shadows the older one (MEM/WB).
  always_comb begin
    fwd_data = reg_data;
    if (exmem_reg_write && (exmem_rd == src_addr) && src_nz)
      fwd_data = exmem_result;
    else if (memwb_reg_write && (memwb_rd == src_addr) && src_nz)
      fwd_data = memwb_data;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{src_addr, exmem_reg_write, exmem_rd, exmem_result,
                        memwb_reg_write, memwb_rd, memwb_data};

  // No forwarding: always the registered operand.
  always_comb begin
    fwd_data = reg_data;
  end
`endif
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand selection and forwarding.
// ALU shift convention: data_1 = shift amount, data_2 = value shifted.
// Optional feature macro: EX_FORWARD_EN (EX/MEM and MEM/WB operand forwarding).
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int CONF_W     = CONF_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst,
  id_ex_stage_if.slave bus
);

  logic                  valid_q;
  logic [CONF_W-1:0]     conf_q;
  logic                  sign_q;
  logic [DATA_W-1:0]     rs_data_q;
  logic [DATA_W-1:0]     rt_data_q;
  logic [DATA_W-1:0]     imm_q;
  logic [SHAMT_W-1:0]    shamt_q;
  logic                  src_a_shamt_q;
  logic                  src_b_imm_q;
  logic [REG_ADDR_W-1:0] rs_q;
  logic [REG_ADDR_W-1:0] rt_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  reg_write_q;
  logic                  mem_read_q;
  logic                  mem_write_q;
  logic                  mem_to_reg_q;

  logic [DATA_W-1:0]     fwd_rs;
  logic [DATA_W-1:0]     fwd_rt;

  ex_forward_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs (
    .src_addr        (rs_q),
    .reg_data        (rs_data_q),
    .exmem_reg_write (bus.i_exmem_reg_write),
    .exmem_rd        (bus.i_exmem_rd),
    .exmem_result    (bus.i_exmem_result),
    .memwb_reg_write (bus.i_memwb_reg_write),
    .memwb_rd        (bus.i_memwb_rd),
    .memwb_data      (bus.i_memwb_data),
    .fwd_data        (fwd_rs)
  );

  ex_forward_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rt (
    .src_addr        (rt_q),
    .reg_data        (rt_data_q),
    .exmem_reg_write (bus.i_exmem_reg_write),
    .exmem_rd        (bus.i_exmem_rd),
    .exmem_result    (bus.i_exmem_result),
    .memwb_reg_write (bus.i_memwb_reg_write),
    .memwb_rd        (bus.i_memwb_rd),
    .memwb_data      (bus.i_memwb_data),
    .fwd_data        (fwd_rt)
  );

  // Pipeline register: reset/flush -> bubble, stall -> hold but refresh the
  // operands from the forward path so a producer retiring mid-stall is kept.
  always_ff @(posedge i_clk) begin
    if (i_rst || bus.i_flush) begin
      valid_q       <= 1'b0;
      conf_q        <= CONF_W'(BUBBLE_CONF);
      sign_q        <= 1'b0;
      rs_data_q     <= '0;
      rt_data_q     <= '0;
      imm_q         <= '0;
      shamt_q       <= '0;
      src_a_shamt_q <= 1'b0;
      src_b_imm_q   <= 1'b0;
      rs_q          <= '0;
      rt_q          <= '0;
      rd_q          <= REG_ADDR_W'(BUBBLE_RD);
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
    end else if (bus.i_stall) begin
      rs_data_q     <= fwd_rs;
      rt_data_q     <= fwd_rt;
    end else begin
      valid_q       <= bus.i_id_valid;
      conf_q        <= bus.i_id_alu_conf;
      sign_q        <= bus.i_id_sign;
      rs_data_q     <= bus.i_id_rs_data;
      rt_data_q     <= bus.i_id_rt_data;
      imm_q         <= bus.i_id_imm;
      shamt_q       <= bus.i_id_shamt;
      src_a_shamt_q <= bus.i_id_src_a_shamt;
      src_b_imm_q   <= bus.i_id_src_b_imm;
      rs_q          <= bus.i_id_rs;
      rt_q          <= bus.i_id_rt;
      rd_q          <= bus.i_id_rd;
      reg_write_q   <= bus.i_id_reg_write;
      mem_read_q    <= bus.i_id_mem_read;
      mem_write_q   <= bus.i_id_mem_write;
      mem_to_reg_q  <= bus.i_id_mem_to_reg;
    end
  end

  // ALU operand selection; only these depend combinationally on forwarding.
  always_comb begin
    bus.o_alu_data_1 = src_a_shamt_q ? {{(DATA_W-SHAMT_W){1'b0}}, shamt_q} : fwd_rs;
    bus.o_alu_data_2 = src_b_imm_q ? imm_q : fwd_rt;
    bus.o_store_data = fwd_rt;
  end

  assign bus.o_valid      = valid_q;
  assign bus.o_alu_conf   = conf_q;
  assign bus.o_alu_sign   = sign_q;
  assign bus.o_rd         = rd_q;
  assign bus.o_reg_write  = reg_write_q;
  assign bus.o_mem_read   = mem_read_q;
  assign bus.o_mem_write  = mem_write_q;
  assign bus.o_mem_to_reg = mem_to_reg_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage; expectations follow EX_FORWARD_EN.
module tb_id_ex_stage;

`ifdef EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [4:0] C_AND = 5'd0, C_ADD = 5'd2, C_SUB = 5'd3, C_SLL = 5'd7, C_SRA = 5'd9;

  typedef struct packed {
    logic        valid;
    logic [4:0]  conf;
    logic        sign;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] store;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic push(input string tag, input logic v, input logic [4:0] conf, input logic sign,
                      input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] st,
                      input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                      input logic m2r);
    exp_t e;
    e = '{valid:v, conf:conf, sign:sign, d1:d1, d2:d2, store:st, rd:rd, rw:rw, mr:mr, mw:mw, m2r:m2r};
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic push_bubble(input string tag);
    push(tag, 1'b0, C_AND, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check();
    exp_t  e, o;
    string t;
    o = '{valid:bus.o_valid, conf:bus.o_alu_conf, sign:bus.o_alu_sign, d1:bus.o_alu_data_1,
          d2:bus.o_alu_data_2, store:bus.o_store_data, rd:bus.o_rd, rw:bus.o_reg_write,
          mr:bus.o_mem_read, mw:bus.o_mem_write, m2r:bus.o_mem_to_reg};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h", o);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (o === e) else begin
        errors++;
        $error("FAIL %s observed v=%b conf=%0d s=%b d1=%h d2=%h st=%h rd=%0d ctl=%b%b%b%b expected v=%b conf=%0d s=%b d1=%h d2=%h st=%h rd=%0d ctl=%b%b%b%b",
               t, o.valid, o.conf, o.sign, o.d1, o.d2, o.store, o.rd, o.rw, o.mr, o.mw, o.m2r,
               e.valid, e.conf, e.sign, e.d1, e.d2, e.store, e.rd, e.rw, e.mr, e.mw, e.m2r);
      end
    end
  endtask

  task automatic tick_check();
    @(posedge clk);
    #2;
    check();
  endtask

  task automatic clr_id();
    bus.i_id_valid = 0; bus.i_id_alu_conf = '0; bus.i_id_sign = 0;
    bus.i_id_rs_data = '0; bus.i_id_rt_data = '0; bus.i_id_imm = '0; bus.i_id_shamt = '0;
    bus.i_id_src_a_shamt = 0; bus.i_id_src_b_imm = 0;
    bus.i_id_rs = '0; bus.i_id_rt = '0; bus.i_id_rd = '0;
    bus.i_id_reg_write = 0; bus.i_id_mem_read = 0; bus.i_id_mem_write = 0; bus.i_id_mem_to_reg = 0;
  endtask

  task automatic clr_fwd();
    bus.i_exmem_reg_write = 0; bus.i_exmem_rd = '0; bus.i_exmem_result = '0;
    bus.i_memwb_reg_write = 0; bus.i_memwb_rd = '0; bus.i_memwb_data = '0;
  endtask

  initial begin
    rst = 1; bus.i_stall = 0; bus.i_flush = 0;
    clr_id(); clr_fwd();

    // Reset held two cycles with a real instruction in ID.
    bus.i_id_valid = 1; bus.i_id_alu_conf = C_ADD; bus.i_id_rs = 1; bus.i_id_rt = 2;
    bus.i_id_rd = 3; bus.i_id_rs_data = 5; bus.i_id_rt_data = 7; bus.i_id_reg_write = 1;
    push_bubble("reset_c1"); tick_check();
    push_bubble("reset_c2"); tick_check();

    // add r3, r1(5), r2(7)
    rst = 0;
    push("add", 1, C_ADD, 0, 32'd5, 32'd7, 32'd7, 5'd3, 1, 0, 0, 0);
    tick_check();

    // sll by shamt=4, rt=1
    clr_id();
    bus.i_id_valid = 1; bus.i_id_alu_conf = C_SLL; bus.i_id_src_a_shamt = 1; bus.i_id_shamt = 4;
    bus.i_id_rs_data = 32'h99; bus.i_id_rt = 2; bus.i_id_rt_data = 1; bus.i_id_rd = 5;
    bus.i_id_reg_write = 1;
    push("sll", 1, C_SLL, 0, 32'd4, 32'd1, 32'd1, 5'd5, 1, 0, 0, 0);
    tick_check();

    // srav with rs=r6 forwarded from EX/MEM as 8
    clr_id();
    bus.i_id_valid = 1; bus.i_id_alu_conf = C_SRA; bus.i_id_sign = 1; bus.i_id_rs = 6;
    bus.i_id_rs_data = 32'h11; bus.i_id_rt = 7; bus.i_id_rt_data = 32'h80; bus.i_id_rd = 9;
    bus.i_id_reg_write = 1;
    bus.i_exmem_reg_write = 1; bus.i_exmem_rd = 6; bus.i_exmem_result = 32'd8;
    push("srav_fwd", 1, C_SRA, 1, FWD ? 32'd8 : 32'h11, 32'h80, 32'h80, 5'd9, 1, 0, 0, 0);
    tick_check();

    // rs=r4 with both EX/MEM and MEM/WB writing r4: EX/MEM wins
    clr_id();
    bus.i_id_valid = 1; bus.i_id_alu_conf = C_ADD; bus.i_id_rs = 4; bus.i_id_rs_data = 32'h10;
    bus.i_id_rt = 2; bus.i_id_rt_data = 3; bus.i_id_rd = 8; bus.i_id_reg_write = 1;
    bus.i_exmem_reg_write = 1; bus.i_exmem_rd = 4; bus.i_exmem_result = 32'hAA;
    bus.i_memwb_reg_write = 1; bus.i_memwb_rd = 4; bus.i_memwb_data = 32'hBB;
    push("fwd_prio_exmem", 1, C_ADD, 0, FWD ? 32'hAA : 32'h10, 32'd3, 32'd3, 5'd8, 1, 0, 0, 0);
    tick_check();

    // EX/MEM off -> MEM/WB value
    bus.i_exmem_reg_write = 0;
    push("fwd_memwb", 1, C_ADD, 0, FWD ? 32'hBB : 32'h10, 32'd3, 32'd3, 5'd8, 1, 0, 0, 0);
    tick_check();

    // $0 never forwarded
    bus.i_id_rs = 0; bus.i_id_rs_data = 32'h33; bus.i_id_rt = 0; bus.i_id_rt_data = 32'h44;
    bus.i_exmem_reg_write = 1; bus.i_exmem_rd = 0; bus.i_exmem_result = 32'hAA;
    bus.i_memwb_reg_write = 1; bus.i_memwb_rd = 0; bus.i_memwb_data = 32'hBB;
    push("fwd_r0", 1, C_ADD, 0, 32'h33, 32'h44, 32'h44, 5'd8, 1, 0, 0, 0);
    tick_check();

    // Stall refresh: load sub, then stall 3 cycles with MEM/WB r2=0x55 on the first only
    clr_id(); clr_fwd();
    bus.i_id_valid = 1; bus.i_id_alu_conf = C_SUB; bus.i_id_rs = 1; bus.i_id_rs_data = 1;
    bus.i_id_rt = 2; bus.i_id_rt_data = 32'h11; bus.i_id_rd = 7; bus.i_id_reg_write = 1;
    push("stall_load", 1, C_SUB, 0, 32'd1, 32'h11, 32'h11, 5'd7, 1, 0, 0, 0);
    tick_check();

    clr_id();
    bus.i_id_rt_data = 32'h99;
    bus.i_stall = 1;
    bus.i_memwb_reg_write = 1; bus.i_memwb_rd = 2; bus.i_memwb_data = 32'h55;
    push("stall_c1", 1, C_SUB, 0, 32'd1, FWD ? 32'h55 : 32'h11, FWD ? 32'h55 : 32'h11, 5'd7, 1, 0, 0, 0);
    tick_check();
    bus.i_memwb_reg_write = 0;
    for (int i = 2; i <= 3; i++) begin
      push($sformatf("stall_c%0d", i), 1, C_SUB, 0, 32'd1, FWD ? 32'h55 : 32'h11,
           FWD ? 32'h55 : 32'h11, 5'd7, 1, 0, 0, 0);
      tick_check();
    end
    bus.i_stall = 0;
    #1;
    push("stall_release", 1, C_SUB, 0, 32'd1, FWD ? 32'h55 : 32'h11, FWD ? 32'h55 : 32'h11,
         5'd7, 1, 0, 0, 0);
    check();

    // Flush + stall with a store in ID -> bubble
    clr_id(); clr_fwd();
    bus.i_id_valid = 1; bus.i_id_alu_conf = C_ADD; bus.i_id_rs = 3; bus.i_id_rs_data = 32'h100;
    bus.i_id_imm = 32'h8; bus.i_id_src_b_imm = 1; bus.i_id_rt = 5; bus.i_id_rt_data = 32'hDEAD;
    bus.i_id_mem_write = 1;
    bus.i_flush = 1; bus.i_stall = 1;
    push_bubble("flush_stall"); tick_check();

    // Same store now loads: base+imm on ALU, rt on store data
    bus.i_flush = 0; bus.i_stall = 0;
    push("store_load", 1, C_ADD, 0, 32'h100, 32'h8, 32'hDEAD, 5'd0, 0, 0, 1, 0);
    tick_check();

    // Reset wins over stall
    rst = 1; bus.i_stall = 1;
    push_bubble("reset_over_stall"); tick_check();
    rst = 0; bus.i_stall = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
